audio_nios_onchip_mem_arbiter: RTL and testbench
================================================

AUDIO_NIOS_ONCHIP_MEM_ARBITER -- requirements
Module: audio_nios_onchip_mem_arbiter

Interface
REQ-001 Parameter DEPTH, default 51200, number of implemented 32-bit words.
REQ-002 Parameter ADDR_W, default 16, word-address width on all ports.
REQ-003 Port clk  input  1  single clock; every register in the block is on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Ports mN_address  input  ADDR_W  master N word address (N = 0 CPU, N = 1 audio DMA).
REQ-006 Ports mN_byteenable  input  4  master N byte lanes.
REQ-007 Ports mN_read, mN_write  input  1 each  master N request strobes.
REQ-008 Ports mN_writedata  input  32  master N write data.
REQ-009 Ports mN_waitrequest  output  1  master N stall.
REQ-010 Ports mN_readdata  output  32  master N read data.
REQ-011 Ports mN_readdatavalid  output  1  master N read data qualifier.
REQ-012 Ports mem_address (ADDR_W), mem_byteenable (4), mem_chipselect (1), mem_write (1), mem_writedata (32), mem_clken (1)  output  RAM-side command.
REQ-013 Port mem_readdata  input  32  RAM read data, valid one cycle after the address is presented.
REQ-014 Port err_count  output  8  saturating count of out-of-range accesses.

Function
REQ-015 The block SHALL accept at most one request per cycle; request_N = mN_read | mN_write.
REQ-016 mN_read and mN_write both high SHALL be treated as a write.
REQ-017 The granted master's waitrequest SHALL be 0 combinationally in the grant cycle; every other requester's waitrequest SHALL be 1.
REQ-018 A non-requesting master SHALL see waitrequest 0.
REQ-019 mem_* command outputs SHALL be driven combinationally from the granted master; with no grant, mem_chipselect = 0 and mem_write = 0.
REQ-020 mem_clken SHALL equal ~reset.
REQ-021 An accepted read SHALL assert the owner's readdatavalid exactly one cycle later, with readdata = mem_readdata; the other master's readdatavalid stays 0.
REQ-022 Back-to-back accepts SHALL sustain one access per cycle, including an alternating read/write mix across masters.
REQ-023 An address >= DEPTH SHALL be accepted with mem_chipselect = 0, write discarded, read returning 32'h0 with readdatavalid; err_count increments, saturating at 255.
REQ-024 The arbiter state SHALL be a last-grant register, with states LAST_M0 and LAST_M1; it updates only on an accepted request.

Reset
REQ-025 While reset is high: both waitrequests = 1, both readdatavalid = 0, mem_chipselect = 0, mem_write = 0, err_count = 0, and last-grant = LAST_M1.
REQ-026 A read accepted in the cycle before reset asserts SHALL NOT produce readdatavalid.
REQ-027 Outputs SHALL be defined in the first cycle after reset deasserts.

Configuration
REQ-028 Macro AUDIO_NIOS_MEM_ARB_RR_EN defined: round-robin; when both masters request, the master not equal to last-grant wins.
REQ-029 Macro undefined: fixed priority, m0 always wins a conflict, and the last-grant register is still maintained but does not influence arbitration.

Structure
REQ-030 A shared package audio_nios_mem_pkg SHALL hold the DEPTH default, the word width (32), the byte-enable width (4), and the last-grant enumerated type.
REQ-031 One sub-module, audio_nios_mem_arb_grant (a two-way grant selector with last-grant state), is natural; the mux and read-return logic stay in the top level.

Verification
REQ-032 m0 reads 0x0010 alone -> m0_waitrequest = 0 in the same cycle; the next cycle m0_readdatavalid = 1 with the preloaded word.
REQ-033 Both masters request continuously, RR_EN defined -> grants alternate m0, m1, m0, ... after reset; RR_EN undefined -> m0 wins every cycle and m1_waitrequest stays 1.
REQ-034 m1 writes 0xDEADBEEF to 0x0100 with byteenable 4'b0011, then m0 reads 0x0100 -> the read returns 0x????BEEF, with the upper bytes unchanged.
REQ-035 m0 reads 0xC800 (51200) -> mem_chipselect = 0, readdata = 0 with valid one cycle later, err_count = 1; 300 such accesses -> err_count = 255.
REQ-036 Reset asserted in the cycle after a read is accepted -> no readdatavalid; all outputs at their reset values.

Source files
------------

// File: rtl/audio_nios_mem_pkg.sv
`default_nettype none
// ==========================================================================
// audio_nios_mem_pkg - shared constants and last-grant type for the on-chip
// memory arbiter. Build macro: AUDIO_NIOS_MEM_ARB_RR_EN.     Revision: 1.0
// ==========================================================================
package audio_nios_mem_pkg;

  localparam int unsigned MEM_DEPTH = 51200;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BE_W      = 4;

`ifdef AUDIO_NIOS_MEM_ARB_RR_EN
  localparam bit ARB_RR_EN = 1'b1;
`else
  localparam bit ARB_RR_EN = 1'b0;
`endif

  typedef enum logic {
    LAST_M0 = 1'b0,
    LAST_M1 = 1'b1
  } last_grant_e;

  // m1 only takes a contended cycle under round-robin, after m0 was served last.
  function automatic logic m1_wins_conflict(input last_grant_e last);
    return ARB_RR_EN && (last == LAST_M0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/audio_nios_mem_arb_grant.sv
`default_nettype none
// ==========================================================================
// audio_nios_mem_arb_grant - two-way grant selector with last-grant state.
// Build macro: AUDIO_NIOS_MEM_ARB_RR_EN.                      Revision: 1.0
// ==========================================================================
module audio_nios_mem_arb_grant
  import audio_nios_mem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  last_grant_e last_q;
  logic        w_m1_wins;

  assign w_m1_wins = m1_wins_conflict(last_q);

  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (!reset) begin
      gnt0_o = req0_i && !(req1_i && w_m1_wins);
      gnt1_o = req1_i && (!req0_i || w_m1_wins);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= LAST_M1;
    end else if (gnt0_o) begin
      last_q <= LAST_M0;
    end else if (gnt1_o) begin
      last_q <= LAST_M1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/audio_nios_onchip_mem_arbiter.sv
`default_nettype none
// ==========================================================================
// audio_nios_onchip_mem_arbiter - shares one on-chip RAM port between the CPU
// (m0) and audio DMA (m1). Build macro: AUDIO_NIOS_MEM_ARB_RR_EN. Rev: 1.0
// ==========================================================================
module audio_nios_onchip_mem_arbiter
  import audio_nios_mem_pkg::*;
#(
  parameter int unsigned DEPTH  = MEM_DEPTH,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,

  output logic [7:0]        err_count
);

  logic              w_req0, w_req1;
  logic              w_gnt0, w_gnt1, w_any;
  logic              w_wr, w_in_range;
  logic [DATA_W-1:0] w_rdata;
  logic              rv0_q, rv1_q, oor_q;
  logic [7:0]        err_q, err_d;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  audio_nios_mem_arb_grant u_grant (
    .clk    (clk),
    .reset  (reset),
    .req0_i (w_req0),
    .req1_i (w_req1),
    .gnt0_o (w_gnt0),
    .gnt1_o (w_gnt1)
  );

  assign w_any = w_gnt0 | w_gnt1;

  // Read+write together counts as a write, so the write strobe alone decides.
  assign w_wr           = w_gnt1 ? m1_write      : m0_write;
  assign mem_address    = w_gnt1 ? m1_address    : m0_address;
  assign mem_byteenable = w_gnt1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = w_gnt1 ? m1_writedata  : m0_writedata;
  assign w_in_range     = 32'(mem_address) < 32'(DEPTH);

  assign mem_chipselect = w_any & w_in_range;
  assign mem_write      = mem_chipselect & w_wr;
  assign mem_clken      = ~reset;

  assign m0_waitrequest = reset | (w_req0 & ~w_gnt0);
  assign m1_waitrequest = reset | (w_req1 & ~w_gnt1);

  always_comb begin
    err_d = err_q;
    if (w_any && !w_in_range && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
      oor_q <= 1'b0;
      err_q <= 8'd0;
    end else begin
      rv0_q <= w_gnt0 & ~m0_write;
      rv1_q <= w_gnt1 & ~m1_write;
      oor_q <= ~w_in_range;
      err_q <= err_d;
    end
  end

  // Reset gating keeps a read accepted just before reset from returning data.
  assign w_rdata          = oor_q ? '0 : mem_readdata;
  assign m0_readdata      = w_rdata;
  assign m1_readdata      = w_rdata;
  assign m0_readdatavalid = rv0_q & ~reset;
  assign m1_readdatavalid = rv1_q & ~reset;
  assign err_count        = reset ? 8'd0 : err_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_nios_onchip_mem_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_audio_nios_onchip_mem_arbiter - table, directed and randomized checks
// against a behavioural model. Build macro: AUDIO_NIOS_MEM_ARB_RR_EN. Rev 1.0
// ==========================================================================
module tb_audio_nios_onchip_mem_arbiter;

  localparam int DEPTH = 51200;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] m0_address, m1_address, mem_address;
  logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, mem_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata, mem_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  audio_nios_onchip_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .err_count(err_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pre(input int a);
    return (32'(a) * 32'h0001_0003) ^ 32'hA5C3_0F0F;
  endfunction

  // RAM fixture: registered read, one cycle latency, preloaded with pre().
  logic [31:0] ram [int];
  initial begin
    int          a;
    logic [31:0] w, wd;
    logic [3:0]  be;
    logic        cs, we, ce;
    mem_readdata = '0;
    forever begin
      @(negedge clk);
      #3;
      a = int'(mem_address); be = mem_byteenable; wd = mem_writedata;
      cs = mem_chipselect; we = mem_write; ce = mem_clken;
      @(posedge clk);
      if (ce) begin
        w = ram.exists(a) ? ram[a] : pre(a);
        mem_readdata = w;
        if (cs && we) begin
          for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
          ram[a] = w;
        end
      end
    end
  end

  // Behavioural reference: expected memory image, last winner, pending read.
  logic [31:0] shadow [int];
  int          m_last = 1;
  int          m_err  = 0;
  bit          p_v0, p_v1;
  logic [31:0] p_data;

  function automatic logic [31:0] sh_rd(input int a);
    return shadow.exists(a) ? shadow[a] : pre(a);
  endfunction

  typedef struct {
    logic r0, w0; logic [15:0] a0; logic [3:0] be0; logic [31:0] d0;
    logic r1, w1; logic [15:0] a1; logic [3:0] be1; logic [31:0] d1;
    bit   chk;
    logic xw0, xw1, xcs, xwe, xrv0, xrv1; logic [31:0] xrd;
  } vec_t;

  function automatic vec_t mk(input logic r0, w0, input logic [15:0] a0,
                              input logic [3:0] be0, input logic [31:0] d0,
                              input logic r1, w1, input logic [15:0] a1,
                              input logic [3:0] be1, input logic [31:0] d1);
    vec_t v;
    v = '{default: '0};
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.be0 = be0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.be1 = be1; v.d1 = d1;
    return v;
  endfunction

  function automatic vec_t xp(input vec_t v, input logic w0, w1, cs, we, rv0, rv1,
                              input logic [31:0] rd);
    vec_t o;
    o = v; o.chk = 1'b1;
    o.xw0 = w0; o.xw1 = w1; o.xcs = cs; o.xwe = we; o.xrv0 = rv0; o.xrv1 = rv1; o.xrd = rd;
    return o;
  endfunction

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input vec_t v, input logic rst_v);
    bit          q0, q1, wr, inr;
    int          win, a;
    logic [3:0]  be;
    logic [31:0] d, cur;
    reset = rst_v;
    m0_read = v.r0; m0_write = v.w0; m0_address = v.a0; m0_byteenable = v.be0; m0_writedata = v.d0;
    m1_read = v.r1; m1_write = v.w1; m1_address = v.a1; m1_byteenable = v.be1; m1_writedata = v.d1;
    q0 = v.r0 | v.w0;
    q1 = v.r1 | v.w1;
    win = -1;
    if (!rst_v) begin
      if (q0 && q1) begin
`ifdef AUDIO_NIOS_MEM_ARB_RR_EN
        win = (m_last == 0) ? 1 : 0;
`else
        win = 0;
`endif
      end else if (q0) win = 0;
      else if (q1) win = 1;
    end
    a   = (win == 1) ? int'(v.a1) : int'(v.a0);
    wr  = (win == 1) ? v.w1 : v.w0;
    be  = (win == 1) ? v.be1 : v.be0;
    d   = (win == 1) ? v.d1 : v.d0;
    inr = a < DEPTH;
    #1;
    chk("wait0", m0_waitrequest, rst_v || (q0 && win != 0));
    chk("wait1", m1_waitrequest, rst_v || (q1 && win != 1));
    chk("chipselect", mem_chipselect, win >= 0 && inr);
    chk("mem_write", mem_write, win >= 0 && inr && wr);
    chk("clken", mem_clken, !rst_v);
    chk("rvalid0", m0_readdatavalid, !rst_v && p_v0);
    chk("rvalid1", m1_readdatavalid, !rst_v && p_v1);
    if (!rst_v && p_v0) chk("rdata0", m0_readdata, p_data);
    if (!rst_v && p_v1) chk("rdata1", m1_readdata, p_data);
    chk("err_count", err_count, rst_v ? 0 : m_err);
    if (win >= 0) begin
      chk("mem_addr", mem_address, a);
      if (wr && inr) begin
        chk("mem_be", mem_byteenable, be);
        chk("mem_wdata", mem_writedata, d);
      end
    end
    if (v.chk) begin
      chk("t_wait0", m0_waitrequest, v.xw0);
      chk("t_wait1", m1_waitrequest, v.xw1);
      chk("t_cs", mem_chipselect, v.xcs);
      chk("t_we", mem_write, v.xwe);
      chk("t_rv0", m0_readdatavalid, v.xrv0);
      chk("t_rv1", m1_readdatavalid, v.xrv1);
      if (v.xrv0) chk("t_rdata0", m0_readdata, v.xrd);
      if (v.xrv1) chk("t_rdata1", m1_readdata, v.xrd);
    end
    p_v0 = 1'b0;
    p_v1 = 1'b0;
    if (rst_v) begin
      m_last = 1;
      m_err  = 0;
    end else if (win >= 0) begin
      m_last = win;
      if (!inr) m_err = (m_err < 255) ? m_err + 1 : 255;
      if (wr) begin
        if (inr) begin
          cur = sh_rd(a);
          for (int b = 0; b < 4; b++) if (be[b]) cur[8*b +: 8] = d[8*b +: 8];
          shadow[a] = cur;
        end
      end else begin
        if (win == 0) p_v0 = 1'b1; else p_v1 = 1'b1;
        p_data = inr ? sh_rd(a) : 32'h0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    vec_t        tbl [12];
    vec_t        idle, v;
    logic [31:0] p100;
    int          win, pwin, prev;

    reset = 1'b1;
    m0_read = 0; m0_write = 0; m0_address = 0; m0_byteenable = 0; m0_writedata = 0;
    m1_read = 0; m1_write = 0; m1_address = 0; m1_byteenable = 0; m1_writedata = 0;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    p100 = pre(32'h100);

    tbl[0]  = xp(mk(1, 0, 16'h0010, 4'hF, 0, 0, 0, 0, 0, 0), 0, 0, 1, 0, 0, 0, 0);
    tbl[1]  = xp(idle, 0, 0, 0, 0, 1, 0, pre(32'h10));
    tbl[2]  = xp(mk(0, 0, 0, 0, 0, 0, 1, 16'h0100, 4'b0011, 32'hDEADBEEF), 0, 0, 1, 1, 0, 0, 0);
    tbl[3]  = xp(mk(1, 0, 16'h0100, 4'hF, 0, 0, 0, 0, 0, 0), 0, 0, 1, 0, 0, 0, 0);
    tbl[4]  = xp(idle, 0, 0, 0, 0, 1, 0, {p100[31:16], 16'hBEEF});
    tbl[5]  = xp(mk(1, 0, 16'hC800, 4'hF, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = xp(idle, 0, 0, 0, 0, 1, 0, 32'h0);
    tbl[7]  = xp(mk(0, 0, 0, 0, 0, 1, 1, 16'h0020, 4'hF, 32'h12345678), 0, 0, 1, 1, 0, 0, 0);
    tbl[8]  = xp(mk(0, 0, 0, 0, 0, 1, 0, 16'h0020, 4'hF, 0), 0, 0, 1, 0, 0, 0, 0);
    tbl[9]  = xp(mk(0, 1, 16'hFFFF, 4'hF, 32'hCAFE0000, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 1, 32'h12345678);
    tbl[10] = xp(mk(1, 0, 16'h0020, 4'hF, 0, 0, 0, 0, 0, 0), 0, 0, 1, 0, 0, 0, 0);
    tbl[11] = xp(idle, 0, 0, 0, 0, 1, 0, 32'h12345678);

    @(negedge clk);
    // Reset with both masters requesting: everything held at reset values.
    for (int i = 0; i < 3; i++)
      step(xp(mk(1, 0, 16'h10, 4'hF, 0, 0, 1, 16'h20, 4'hF, 1), 1, 1, 0, 0, 0, 0, 0), 1'b1);
    for (int i = 0; i < 12; i++) step(tbl[i], 1'b0);
    chk("err_after_table", err_count, 8'd2);

    // Continuous contention from a fresh reset.
    step(idle, 1'b1);
    pwin = -1; prev = 0;
    for (int i = 0; i < 8; i++) begin
`ifdef AUDIO_NIOS_MEM_ARB_RR_EN
      win = i % 2;
`else
      win = 0;
`endif
      v = mk(1, 0, 16'(i), 4'hF, 0, 1, 0, 16'(40 + i), 4'hF, 0);
      step(xp(v, win != 0, win != 1, 1, 0, pwin == 0, pwin == 1,
              (pwin == 0) ? pre(prev) : pre(40 + prev)), 1'b0);
      pwin = win; prev = i;
    end
    step(idle, 1'b0);

    // Alternating write/read across masters, one access per cycle.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) step(mk(0, 1, 16'h0032, 4'hF, 32'h1111_0000 + 32'(i), 0, 0, 0, 0, 0), 1'b0);
      else            step(mk(0, 0, 0, 0, 0, 1, 0, 16'h0032, 4'hF, 0), 1'b0);
    end
    step(idle, 1'b0);

    // Out-of-range storm: error counter saturates.
    for (int i = 0; i < 300; i++)
      step(mk(1, 0, 16'($urandom_range(DEPTH, 65535)), 4'hF, 0, 0, 0, 0, 0, 0), 1'b0);
    step(idle, 1'b0);
    chk("err_saturated", err_count, 8'd255);

    // Reset lands the cycle after an accepted read.
    step(mk(1, 0, 16'h0010, 4'hF, 0, 0, 0, 0, 0, 0), 1'b0);
    step(xp(mk(1, 0, 16'h0010, 4'hF, 0, 0, 0, 0, 0, 0), 1, 1, 0, 0, 0, 0, 0), 1'b1);
    step(xp(idle, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    chk("err_after_reset", err_count, 8'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      v = mk($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
             ($urandom_range(0, 7) == 0) ? 16'($urandom_range(DEPTH, 65535)) : 16'($urandom_range(0, 63)),
             4'($urandom), $urandom,
             $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
             ($urandom_range(0, 7) == 0) ? 16'($urandom_range(DEPTH, 65535)) : 16'($urandom_range(0, 63)),
             4'($urandom), $urandom);
      step(v, ($urandom_range(0, 99) == 0));
    end
    step(idle, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
